// File: rtl/lcd_pkg.sv
// Shared constants and types for the character-LCD driver: HD44780 command
// bytes, per-row DDRAM start addresses and the sequencer state encoding.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;

    localparam logic [7:0] ROW_ADDR [0:3] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    localparam logic [7:0] INIT_CMD [0:3] = '{FUNC_SET, DISP_ON, CLEAR, ENTRY};

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        ADDR,
        CHARS,
        DONE,
        IDLE
    } lcd_state_e;

    typedef enum logic {
        PHASE_A,
        PHASE_B
    } lcd_phase_e;

    // One spare code so an address at or past the end of the buffer can be
    // presented on the bus and rejected, even when ROWS*COLS is a power of two.
    function automatic int addr_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// Host write port and panel bus of the character-LCD driver.
// master = host side / observer, slave = the driver itself.
interface lcd_text_driver_if #(
    parameter int AW = 6
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          refresh_req;
    logic          busy;
    logic          LCD_ON;
    logic          LCD_RS;
    logic          LCD_EN;
    logic          LCD_RW;
    logic [7:0]    LCD_DATA;

    modport master (
        output wr_en, wr_addr, wr_data, refresh_req,
        input  busy, LCD_ON, LCD_RS, LCD_EN, LCD_RW, LCD_DATA
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh_req,
        output busy, LCD_ON, LCD_RS, LCD_EN, LCD_RW, LCD_DATA
    );

endinterface

// File: rtl/lcd_tick_gen.sv
// Clock-enable generator: one-cycle tick every CLK_HZ/TICK_HZ system clocks,
// so the LCD sequencer can run on the system clock instead of a divided one.
module lcd_tick_gen #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 400
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/lcd_text_driver.sv
// Character-LCD driver: holds a ROWS x COLS text buffer and streams it to an
// HD44780-class panel, advancing one half byte-transfer per clock-enable tick.
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int TICK_HZ       = 400,
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int POWERUP_TICKS = 8,
    parameter int AUTO_REFRESH  = 1
) (
    input logic              clk,
    input logic              resetn,
    lcd_text_driver_if.slave bus
);
    localparam int N    = ROWS * COLS;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int RW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW   = $clog2(POWERUP_TICKS + 1);

    localparam logic [RW_W-1:0] ROW_LAST = RW_W'(ROWS - 1);
    localparam logic [CW_W-1:0] COL_LAST = CW_W'(COLS - 1);
    localparam logic [PW-1:0]   PWR_LAST = PW'(POWERUP_TICKS - 1);

    lcd_state_e      state_q, state_d;
    lcd_phase_e      phase_q, phase_d;
    logic [1:0]      step_q, step_d;
    logic [RW_W-1:0] row_q, row_d;
    logic [CW_W-1:0] col_q, col_d;
    logic [PW-1:0]   pwr_q, pwr_d;
    logic            dirty_q, dirty_d;
    logic            pending_q, pending_d;
    logic            rs_q, rs_d;
    logic            en_q, en_d;
    logic [7:0]      data_q, data_d;
    logic            on_q;
    logic [7:0]      buf_q [N];

    logic            tick;
    logic            wrHit;
    logic            restartPass;
    logic [IW-1:0]   charIdx;
    logic [IW-1:0]   wrIdx;
    logic [1:0]      rowSel;

    lcd_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk   (clk),
        .resetn(resetn),
        .tick  (tick)
    );

    assign wrHit   = bus.wr_en && (int'(bus.wr_addr) < N);
    assign wrIdx   = IW'(bus.wr_addr);
    assign charIdx = IW'(int'(row_q) * COLS + int'(col_q));
    assign rowSel  = 2'(row_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else if (wrHit) begin
            buf_q[wrIdx] <= bus.wr_data;
        end
    end

    // Byte transfers take two ticks: phase A drives RS/DATA with EN high,
    // phase B drops EN and moves the sequencer on to the next byte.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        row_d       = row_q;
        col_d       = col_q;
        pwr_d       = pwr_q;
        rs_d        = rs_q;
        en_d        = en_q;
        data_d      = data_q;
        restartPass = 1'b0;

        if (tick) begin
            unique case (state_q)
                PWRUP: begin
                    if (pwr_q == PWR_LAST) begin
                        state_d = INIT;
                    end else begin
                        pwr_d = pwr_q + 1'b1;
                    end
                end
                INIT, ADDR, CHARS: begin
                    if (phase_q == PHASE_A) begin
                        en_d    = 1'b1;
                        phase_d = PHASE_B;
                        rs_d    = (state_q == CHARS);
                        if (state_q == INIT) begin
                            data_d = INIT_CMD[step_q];
                        end else if (state_q == ADDR) begin
                            data_d = ROW_ADDR[rowSel];
                        end else begin
                            data_d = buf_q[charIdx];
                        end
                    end else begin
                        en_d    = 1'b0;
                        phase_d = PHASE_A;
                        if (state_q == INIT) begin
                            if (step_q == 2'd3) begin
                                state_d = ADDR;
                                row_d   = '0;
                            end else begin
                                step_d = step_q + 1'b1;
                            end
                        end else if (state_q == ADDR) begin
                            state_d = CHARS;
                            col_d   = '0;
                        end else if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                state_d = DONE;
                            end else begin
                                row_d   = row_q + 1'b1;
                                state_d = ADDR;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                DONE, IDLE: begin
                    if ((state_q == DONE && AUTO_REFRESH != 0) || dirty_q || pending_q) begin
                        state_d     = ADDR;
                        row_d       = '0;
                        restartPass = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = PWRUP;
                end
            endcase
        end
    end

    // A write or request arriving on the very cycle a pass restarts must
    // survive the clear, so the set terms take priority.
    always_comb begin
        dirty_d   = dirty_q;
        pending_d = pending_q;
        if (restartPass) begin
            dirty_d   = 1'b0;
            pending_d = 1'b0;
        end
        if (wrHit) begin
            dirty_d = 1'b1;
        end
        if (bus.refresh_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= PWRUP;
            phase_q   <= PHASE_A;
            step_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pwr_q     <= '0;
            dirty_q   <= 1'b0;
            pending_q <= 1'b0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= 8'h00;
            on_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pwr_q     <= pwr_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            data_q    <= data_d;
            on_q      <= 1'b1;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.LCD_ON   = on_q;
    assign bus.LCD_RS   = rs_q;
    assign bus.LCD_EN   = en_q;
    assign bus.LCD_RW   = 1'b0;
    assign bus.LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Self-checking bench for lcd_text_driver: captures every EN pulse as an
// {RS,DATA} byte and compares the stream with hand-derived expectations.
module tb_lcd_text_driver;
    import lcd_pkg::*;

    localparam int CLK_HZ   = 4000;
    localparam int TICK_HZ  = 400;
    localparam int COLS     = 16;
    localparam int ROWS     = 2;
    localparam int PWR      = 8;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int N        = ROWS * COLS;
    localparam int AW       = addr_width(N);
    localparam int PASS_LEN = ROWS * (COLS + 1);

    typedef struct {
        string         name;
        logic          wrEn;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic          expRs;
        logic [7:0]    expData;
    } vec_t;

    logic clk;
    logic resetn;

    lcd_text_driver_if #(.AW(AW)) bus ();
    lcd_text_driver_if #(.AW(AW)) busAuto ();

    lcd_text_driver #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .COLS(COLS), .ROWS(ROWS),
        .POWERUP_TICKS(PWR), .AUTO_REFRESH(0)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    lcd_text_driver #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .COLS(COLS), .ROWS(ROWS),
        .POWERUP_TICKS(PWR), .AUTO_REFRESH(1)
    ) dutAuto (
        .clk   (clk),
        .resetn(resetn),
        .bus   (busAuto)
    );

    int         nChecks = 0;
    int         nFails  = 0;
    logic [8:0] byteQ [$];
    logic [8:0] autoQ [$];
    logic [7:0] shadow [N];
    logic [7:0] rowCmd [ROWS];
    vec_t       initVec [4];
    vec_t       pidVec [5];
    logic       enPrev = 1'b0;
    int         hiCnt = 0;
    logic       autoPrev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Byte capture and EN pulse-width check on the main driver.
    always @(negedge clk) begin
        if (!resetn) begin
            enPrev = 1'b0;
            hiCnt  = 0;
        end else begin
            if (bus.LCD_EN && !enPrev) begin
                byteQ.push_back({bus.LCD_RS, bus.LCD_DATA});
                hiCnt = 1;
            end else if (bus.LCD_EN) begin
                hiCnt++;
            end else if (enPrev) begin
                checkOutput("en_pulse_width", hiCnt, DIV);
            end
            enPrev = bus.LCD_EN;
        end
    end

    always @(negedge clk) begin
        if (resetn && busAuto.LCD_EN && !autoPrev) begin
            autoQ.push_back({busAuto.LCD_RS, busAuto.LCD_DATA});
        end
        autoPrev = resetn && busAuto.LCD_EN;
    end

    function automatic vec_t mkVec(input string n, input logic w, input logic [AW-1:0] a,
                                   input logic [7:0] d, input logic r, input logic [7:0] e);
        vec_t v;
        v.name = n; v.wrEn = w; v.addr = a; v.wdata = d; v.expRs = r; v.expData = e;
        return v;
    endfunction

    task automatic applyStimulus(input logic wrEn, input logic [AW-1:0] addr,
                                 input logic [7:0] data, input logic refresh);
        bus.wr_en       = wrEn;
        bus.wr_addr     = addr;
        bus.wr_data     = data;
        bus.refresh_req = refresh;
        @(negedge clk);
        bus.wr_en       = 1'b0;
        bus.refresh_req = 1'b0;
    endtask

    task automatic writeChar(input logic [AW-1:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, addr, data, 1'b0);
        if (int'(addr) < N) shadow[addr] = data;
    endtask

    task automatic expectByte(input string name, input logic [8:0] expected);
        int         n;
        logic [8:0] got;
        n = 0;
        while (byteQ.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        got = (byteQ.size() > 0) ? byteQ.pop_front() : 9'bx;
        checkOutput(name, {23'd0, got}, {23'd0, expected});
    endtask

    task automatic expectPass(input string tag, input int firstPos, input int lastPos,
                              input int hookPos, input logic [AW-1:0] hAddr, input logic [7:0] hData);
        int         row;
        int         col;
        logic [8:0] expected;
        for (int p = firstPos; p <= lastPos; p++) begin
            row = p / (COLS + 1);
            col = p % (COLS + 1) - 1;
            expected = (col < 0) ? {1'b0, rowCmd[row]} : {1'b1, shadow[row * COLS + col]};
            expectByte($sformatf("%s_pos%0d", tag, p), expected);
            if (p == PASS_LEN - 1) checkOutput({tag, "_busy_last_byte"}, bus.busy, 1);
            if (p == hookPos) writeChar(hAddr, hData);
        end
    endtask

    task automatic checkQuiet(input string name, input int cycles, input logic expBusy);
        logic sawEn;
        logic busyBad;
        sawEn   = 1'b0;
        busyBad = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.LCD_EN !== 1'b0) sawEn = 1'b1;
            if (bus.busy !== expBusy) busyBad = 1'b1;
        end
        checkOutput({name, "_en_seen"}, sawEn, 0);
        checkOutput({name, "_busy_changed"}, busyBad, 0);
        checkOutput({name, "_bytes"}, byteQ.size(), 0);
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, bus.busy, 0);
    endtask

    task automatic runInit(input string tag, input logic pulseRefresh);
        for (int i = 0; i < 4; i++) begin
            expectByte({tag, "_", initVec[i].name}, {initVec[i].expRs, initVec[i].expData});
            if (i == 0 && pulseRefresh) begin
                repeat (3) begin
                    applyStimulus(1'b0, '0, 8'h00, 1'b1);
                    repeat (2) @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rowCmd[0] = 8'h80;
        rowCmd[1] = 8'hC0;
        initVec[0] = mkVec("func_set", 1'b0, '0, 8'h00, 1'b0, 8'h38);
        initVec[1] = mkVec("disp_on",  1'b0, '0, 8'h00, 1'b0, 8'h0C);
        initVec[2] = mkVec("clear",    1'b0, '0, 8'h00, 1'b0, 8'h01);
        initVec[3] = mkVec("entry",    1'b0, '0, 8'h00, 1'b0, 8'h06);
        pidVec[0]  = mkVec("pid_P",    1'b1, AW'(0), 8'h50, 1'b1, 8'h50);
        pidVec[1]  = mkVec("pid_I",    1'b1, AW'(1), 8'h49, 1'b1, 8'h49);
        pidVec[2]  = mkVec("pid_D",    1'b1, AW'(2), 8'h44, 1'b1, 8'h44);
        pidVec[3]  = mkVec("pid_sp",   1'b1, AW'(3), 8'h20, 1'b1, 8'h20);
        pidVec[4]  = mkVec("pid_7",    1'b1, AW'(4), 8'h37, 1'b1, 8'h37);
        for (int i = 0; i < N; i++) shadow[i] = 8'h20;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h00; bus.refresh_req = 1'b0;
        busAuto.wr_en = 1'b0; busAuto.wr_addr = '0; busAuto.wr_data = 8'h00; busAuto.refresh_req = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_lcd_on", bus.LCD_ON, 0);
        checkOutput("rst_lcd_rs", bus.LCD_RS, 0);
        checkOutput("rst_lcd_en", bus.LCD_EN, 0);
        checkOutput("rst_lcd_rw", bus.LCD_RW, 0);
        checkOutput("rst_lcd_data", bus.LCD_DATA, 8'h00);
        checkOutput("rst_busy", bus.busy, 1);

        // Power-up silence, init with three collapsed refresh requests, two passes.
        resetn = 1'b1;
        checkQuiet("pwrup", 80, 1'b1);
        checkOutput("pwrup_lcd_on", bus.LCD_ON, 1);
        runInit("init", 1'b1);
        expectPass("pass_initial", 0, PASS_LEN - 1, -1, '0, 8'h00);
        expectPass("pass_refresh", 0, PASS_LEN - 1, -1, '0, 8'h00);
        waitIdle("refresh_collapse_idle", 60);

        // "PID 7" written while idle triggers exactly one pass.
        for (int i = 0; i < 5; i++) begin
            if (pidVec[i].wrEn) writeChar(pidVec[i].addr, pidVec[i].wdata);
        end
        expectByte("pid_row0_cmd", {1'b0, 8'h80});
        for (int i = 0; i < 5; i++) begin
            expectByte(pidVec[i].name, {pidVec[i].expRs, pidVec[i].expData});
        end
        expectPass("pid_rest", 6, PASS_LEN - 1, -1, '0, 8'h00);
        waitIdle("pid_idle", 60);

        writeChar(AW'(N), 8'h5A);
        checkQuiet("oob_write", 100, 1'b0);

        // Mid-pass write at col 10 to address 5 forces a follow-up pass.
        applyStimulus(1'b0, '0, 8'h00, 1'b1);
        expectPass("midwr_pass1", 0, PASS_LEN - 1, 11, AW'(5), 8'h58);
        checkOutput("midwr_shadow_x", shadow[5], 8'h58);
        expectPass("midwr_pass2", 0, PASS_LEN - 1, -1, '0, 8'h00);
        waitIdle("midwr_idle", 60);

        begin
            int n;
            n = 0;
            while (autoQ.size() < 4 + 2 * PASS_LEN + 1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            checkOutput("auto_pass1_row0", {23'd0, autoQ[4]}, {23'd0, 1'b0, 8'h80});
            checkOutput("auto_pass1_row1", {23'd0, autoQ[4 + COLS + 1]}, {23'd0, 1'b0, 8'hC0});
            checkOutput("auto_pass1_last", {23'd0, autoQ[4 + PASS_LEN - 1]}, {23'd0, 1'b1, 8'h20});
            checkOutput("auto_pass2_row0", {23'd0, autoQ[4 + PASS_LEN]}, {23'd0, 1'b0, 8'h80});
            checkOutput("auto_busy", busAuto.busy, 1);
        end

        // Reset in the middle of CHARS, then full replay with a cleared buffer.
        applyStimulus(1'b0, '0, 8'h00, 1'b1);
        expectPass("prereset", 0, 4, -1, '0, 8'h00);
        #2 resetn = 1'b0;
        #1;
        checkOutput("midrst_lcd_en", bus.LCD_EN, 0);
        checkOutput("midrst_lcd_data", bus.LCD_DATA, 8'h00);
        checkOutput("midrst_lcd_on", bus.LCD_ON, 0);
        checkOutput("midrst_busy", bus.busy, 1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        byteQ.delete();
        for (int i = 0; i < N; i++) shadow[i] = 8'h20;
        checkQuiet("rerun_pwrup", 80, 1'b1);
        runInit("rerun_init", 1'b0);
        expectPass("rerun_pass", 0, PASS_LEN - 1, -1, '0, 8'h00);
        waitIdle("rerun_idle", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
